score_keeper: RTL

- Upstream of the LED animation stage; converts raw ball-exit events from the ball/playfield logic into per-player scores and emits the goal/win signals that the animation stage consumes.
- Freezes play for a fixed pause after each point so the goal animation (~108 ball ticks) completes before the next serve.
- Holds the game in a game-over state after a win until a new game is requested.
- Runs on the ball tick clock.

---
 rtl/score_keeper_if.sv | 29 ++
 rtl/score_keeper.sv | 106 ++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
// Event and score bundle between the playfield logic, the score keeper and the LED animation stage.
interface score_keeper_if #(
    parameter int SCORE_WIDTH = 4
);
    logic                   ball_exit_left;
    logic                   ball_exit_right;
    logic                   new_game;
    logic                   goal_player_1;
    logic                   goal_player_2;
    logic                   win_player_1;
    logic                   win_player_2;
    logic [SCORE_WIDTH-1:0] score_player_1;
    logic [SCORE_WIDTH-1:0] score_player_2;
    logic                   game_active;
    logic                   ball_reset;
    logic                   serve_to_player_1;

    modport master (
        output ball_exit_left, ball_exit_right, new_game,
        input  goal_player_1, goal_player_2, win_player_1, win_player_2,
        input  score_player_1, score_player_2, game_active, ball_reset, serve_to_player_1
    );

    modport slave (
        input  ball_exit_left, ball_exit_right, new_game,
        output goal_player_1, goal_player_2, win_player_1, win_player_2,
        output score_player_1, score_player_2, game_active, ball_reset, serve_to_player_1
    );
endinterface

// File: rtl/score_keeper.sv
// Turns ball-exit events into per-player scores, goal/win pulses and serve control,
// freezing play for a fixed pause after every point so the goal animation can finish.
module score_keeper #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_WIDTH = 4,
    parameter int PAUSE_TICKS = 112
) (
    input  logic           BALL_CLOCK,
    input  logic           RESET_N,
    score_keeper_if.slave  bus
);
    localparam int CW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [CW-1:0]          PAUSE_LOAD = CW'(PAUSE_TICKS - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VALUE  = SCORE_WIDTH'(WIN_SCORE);

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        PAUSE      = 2'd1,
        PLAY       = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          pause_count;
    logic [SCORE_WIDTH-1:0] inc_player_1;
    logic [SCORE_WIDTH-1:0] inc_player_2;

    assign inc_player_1 = bus.score_player_1 + SCORE_WIDTH'(1);
    assign inc_player_2 = bus.score_player_2 + SCORE_WIDTH'(1);

    // new_game overrides everything, including an exit on the same edge
    always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state                 <= WAIT_START;
            pause_count           <= '0;
            bus.score_player_1    <= '0;
            bus.score_player_2    <= '0;
            bus.goal_player_1     <= 1'b0;
            bus.goal_player_2     <= 1'b0;
            bus.win_player_1      <= 1'b0;
            bus.win_player_2      <= 1'b0;
            bus.ball_reset        <= 1'b0;
            bus.game_active       <= 1'b0;
            bus.serve_to_player_1 <= 1'b1;
        end else begin
            bus.goal_player_1 <= 1'b0;
            bus.goal_player_2 <= 1'b0;
            bus.win_player_1  <= 1'b0;
            bus.win_player_2  <= 1'b0;
            bus.ball_reset    <= 1'b0;
            if (bus.new_game) begin
                bus.score_player_1 <= '0;
                bus.score_player_2 <= '0;
                pause_count        <= PAUSE_LOAD;
                bus.game_active    <= 1'b0;
                state              <= PAUSE;
            end else begin
                case (state)
                    WAIT_START: begin
                        bus.game_active <= 1'b0;
                    end
                    PAUSE: begin
                        if (pause_count == '0) begin
                            bus.ball_reset  <= 1'b1;
                            bus.game_active <= 1'b1;
                            state           <= PLAY;
                        end else begin
                            pause_count <= pause_count - CW'(1);
                        end
                    end
                    PLAY: begin
                        // A simultaneous exit on both edges is treated as a glitch and ignored
                        if (bus.ball_exit_left ^ bus.ball_exit_right) begin
                            bus.game_active       <= 1'b0;
                            bus.serve_to_player_1 <= bus.ball_exit_left;
                            if (bus.ball_exit_right) begin
                                bus.score_player_1 <= inc_player_1;
                                if (inc_player_1 == WIN_VALUE) begin
                                    bus.win_player_1 <= 1'b1;
                                    state            <= WAIT_START;
                                end else begin
                                    bus.goal_player_1 <= 1'b1;
                                    pause_count       <= PAUSE_LOAD;
                                    state             <= PAUSE;
                                end
                            end else begin
                                bus.score_player_2 <= inc_player_2;
                                if (inc_player_2 == WIN_VALUE) begin
                                    bus.win_player_2 <= 1'b1;
                                    state            <= WAIT_START;
                                end else begin
                                    bus.goal_player_2 <= 1'b1;
                                    pause_count       <= PAUSE_LOAD;
                                    state             <= PAUSE;
                                end
                            end
                        end
                    end
                    default: begin
                        bus.game_active <= 1'b0;
                        state           <= WAIT_START;
                    end
                endcase
            end
        end
    end
endmodule
